store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer on the data path, between single_arm's data port (DataAdr/WriteData/MemWrite)
//  and a slower handshaked data memory.
//  - Stores retire in one cycle into a FIFO, which drains in the background.
//  - Loads are serviced in program order with respect to buffered stores.
//  - Stall holds the core's PC while a store cannot be accepted or a load is pending.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  AW      32  address width
//  DW      32  data width
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  Reset      in   1   synchronous, active-high
//  MemWrite   in   1   core store request
//  MemRead    in   1   core load request
//  DataAdr    in   AW  core byte address; bits [1:0] ignored (word access)
//  WriteData  in   DW  core store data
//  ReadData   out  DW  load data to core; valid when MemRead=1 and Stall=0
//  Stall      out  1   core must hold PC and all request inputs
//  mem_req    out  1   memory request; held until mem_ack
//  mem_we     out  1   1=write, 0=read; stable while mem_req=1
//  mem_addr   out  AW  {addr[AW-1:2],2'b00}; stable while mem_req=1
//  mem_wdata  out  DW  write data; stable while mem_req=1
//  mem_ack    in   1   one-cycle completion pulse; mem_rdata valid with it on reads
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  Reset: FIFO empty; rd/wr pointers = 0; state = IDLE.
//   Registered outputs (mem_req, mem_we, mem_addr, mem_wdata, ReadData latch) = 0.
//   Reset mid-transaction discards the in-flight access and all buffered stores.
//  FIFO: pointers are log2(DEPTH)+1 bits with a wrap bit.
//   - full  = MSBs differ, low bits equal.
//   - empty = pointers equal.
//  Push: MemWrite & !full -> entry {word addr, data} written at wr_ptr; the store retires that cycle.
//  Full: MemWrite & full -> Stall=1, no push. A pop in the same cycle does not bypass;
//   the push happens the next cycle.
//  Simultaneous push and pop (not full): count unchanged.
//  MemWrite & MemRead both high: treated as a store; MemRead ignored.
//  FSM:
//   IDLE
//    - !empty -> WR: drive head entry, mem_we=1.
//    - else MemRead (no forward hit) -> RD: mem_we=0, mem_addr=DataAdr word.
//    - Drains take priority over loads.
//   WR
//    - mem_req=1 until mem_ack.
//    - On ack: pop head. Next state is WR (next head) if entries remain, else IDLE.
//   RD
//    - mem_req=1 until mem_ack.
//    - On ack: latch mem_rdata -> DONE.
//   DONE
//    - ReadData = latch, Stall=0 for exactly one cycle -> IDLE.
//  mem_req rises the cycle after entry to WR/RD and falls the cycle after mem_ack.
//   Minimum load latency with an empty FIFO: 3 cycles of Stall.
//  Stall = (MemWrite & full) | (MemRead & !MemWrite & state!=DONE & !fwd_hit).
//  Loads never bypass older buffered stores: a load waits until the FIFO is empty
//   (unless forwarded).
// CONFIGURATION
//  STORE_FORWARD_EN
//   defined:
//    - MemRead compares its word address against all valid entries.
//    - On a hit, ReadData = data of the youngest matching entry, combinationally.
//    - Stall=0; no memory read is issued.
//    - A miss still waits for the drain.
//   undefined: fwd_hit = 0; all loads wait for an empty FIFO, then read memory.
// TESTING
//  T1 Store then drain: STR 0x100<=0xDEADBEEF, mem_ack 2 cycles after mem_req
//      -> no Stall; one write {0x100, 0xDEADBEEF}; FIFO empty afterwards.
//  T2 Full: DEPTH=4, 5 back-to-back stores, mem_ack held low
//      -> Stall on store 5 only.
//      Release ack -> store 5 pushed the cycle after the first pop; writes issued in order.
//  T3 Load after stores, forwarding off: STR 0x200<=0x11, then LDR 0x200 with memory returning 0x11
//      -> write issued before read; ReadData=0x11 in DONE.
//  T4 Forwarding (STORE_FORWARD_EN): STR 0x40<=0xA, STR 0x40<=0xB, LDR 0x40 with ack held low
//      -> same-cycle ReadData=0xB, Stall=0, no read request.
//  T5 Reset mid-write: Reset asserted with mem_req=1, FIFO holding 3 entries
//      -> next cycle mem_req=0, empty, state IDLE; later mem_ack ignored.
//  T6 Address alignment: STR to 0x103 -> mem_addr=0x100.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between the core data port and a handshaked
//               data memory; loads stay ordered behind buffered stores.
//               Optional STORE_FORWARD_EN forwards loads from buffered stores.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic [DW-1:0] ReadData,
    output logic          Stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int c_PW = $clog2(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WR   = 2'd1;
    localparam logic [1:0] c_RD   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [c_PW:0]   r_wr_ptr;
    logic [c_PW:0]   r_rd_ptr;
    logic [AW-1:0]   r_fifo_addr [DEPTH];
    logic [DW-1:0]   r_fifo_data [DEPTH];
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_rdata;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic            w_remain;
    logic            w_fwd_hit;
    logic [DW-1:0]   w_fwd_data;
    logic [c_PW:0]   w_rd_ptr_nxt;
    logic [c_PW-1:0] w_head_idx;
    logic [AW-1:0]   w_word_adr;
    logic            w_unused_adr_bits;

    assign w_word_adr        = {DataAdr[AW-1:2], 2'b00};
    assign w_unused_adr_bits = ^DataAdr[1:0];

    assign w_full  = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                     (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_head_idx   = r_rd_ptr[c_PW-1:0];
    assign w_rd_ptr_nxt = r_rd_ptr + (c_PW+1)'(1);

    // A store with the load strobe also high is still just a store.
    assign w_load = MemRead & ~MemWrite;
    assign w_push = MemWrite & ~w_full;
    assign w_pop  = (r_state == c_WR) & r_mem_req & mem_ack;

    // Entries left after this pop, counting a store arriving in the same cycle.
    assign w_remain = (w_rd_ptr_nxt != r_wr_ptr) | w_push;

`ifdef STORE_FORWARD_EN
    logic [c_PW:0]   w_count;
    logic [c_PW-1:0] w_idx;
    logic            w_match;

    assign w_count = r_wr_ptr - r_rd_ptr;

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        w_match    = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_head_idx + c_PW'(i);
            if (((c_PW+1)'(i) < w_count) && (r_fifo_addr[w_idx] == w_word_adr)) begin
                w_match    = 1'b1;
                w_fwd_data = r_fifo_data[w_idx];
            end
        end
        w_fwd_hit = w_match & w_load;
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    assign Stall    = (MemWrite & w_full) |
                      (w_load & (r_state != c_DONE) & ~w_fwd_hit);
    assign ReadData = w_fwd_hit ? w_fwd_data : r_rdata;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Storage needs no reset: validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[c_PW-1:0]] <= w_word_adr;
            r_fifo_data[r_wr_ptr[c_PW-1:0]] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= c_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_PW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end

            case (r_state)
                c_IDLE: begin
                    if (!w_empty) begin
                        r_state <= c_WR;
                    end else if (w_load && !w_fwd_hit) begin
                        r_state <= c_RD;
                    end
                end
                c_WR: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_fifo_addr[w_head_idx];
                        r_mem_wdata <= r_fifo_data[w_head_idx];
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= w_remain ? c_WR : c_IDLE;
                    end
                end
                c_RD: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_word_adr;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= mem_rdata;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
